// File: rtl/fib_sweep_ctrl.sv
// Start/done sequencer for the iterative Fibonacci datapath: sweeps the step index,
// latches each result for display, holds it, and restarts the sweep on N-bit overflow.
module fib_sweep_ctrl #(
  parameter int N    = 6,
  parameter int HOLD = 50_000_000,
  parameter int TMO  = 1024
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         run,
  input  logic         single,
  output logic         fib_start,
  output logic [N-1:0] fib_steps,
  input  logic         fib_done,
  input  logic [N-1:0] fib_ret,
  output logic [N-1:0] disp_val,
  output logic [N-1:0] disp_idx,
  output logic         ovf,
  output logic         err,
  output logic         busy
);

  // One shared down-counter serves both the datapath timeout and the display hold.
  localparam int CMAX = (HOLD > TMO) ? HOLD : TMO;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;
  localparam logic [CW-1:0] HOLD_LD = CW'(HOLD - 1);
  localparam logic [CW-1:0] TMO_LD  = CW'(TMO - 1);

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_HOLD} state_t;

  state_t        state;
  logic [N-1:0]  idx;
  logic [N-1:0]  prev;
  logic [CW-1:0] cnt;

  assign fib_steps = idx;
  assign busy      = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      prev      <= '0;
      cnt       <= '0;
      disp_val  <= '0;
      disp_idx  <= '0;
      fib_start <= 1'b0;
      ovf       <= 1'b0;
      err       <= 1'b0;
    end else begin
      fib_start <= 1'b0;
      case (state)
        S_IDLE: begin
          if (run || single) begin
            state     <= S_START;
            fib_start <= 1'b1;
          end
        end
        S_START: begin
          cnt   <= TMO_LD;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // A done arriving on the last timeout cycle still counts as success.
          if (fib_done) begin
            disp_val <= fib_ret;
            disp_idx <= idx;
            prev     <= fib_ret;
            if ((idx >= N'(2)) && (fib_ret < prev)) begin
              ovf <= 1'b1;
              idx <= '0;
            end else begin
              idx <= idx + N'(1);
            end
            cnt   <= HOLD_LD;
            state <= S_HOLD;
          end else if (cnt == '0) begin
            err   <= 1'b1;
            state <= S_IDLE;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_HOLD: begin
          if (cnt == '0) begin
            if (run) begin
              state     <= S_START;
              fib_start <= 1'b1;
            end else begin
              state <= S_IDLE;
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fib_sweep_ctrl.sv
// Bench for fib_sweep_ctrl: latency-3 Fibonacci datapath model, result scoreboard,
// table-driven sweep expectations and hand-written timeout/abort/reset sequences.
module tb_fib_sweep_ctrl;
  localparam int N = 6, HOLD = 4, TMO = 16, L = 3;

  typedef struct {
    logic [N-1:0] idx;
    logic [N-1:0] val;
    logic         ovf;
  } exp_t;

  logic clk = 1'b0, reset = 1'b1, run = 1'b0, single = 1'b0;
  logic fib_start, fib_done, ovf, err, busy;
  logic [N-1:0] fib_steps, fib_ret, disp_val, disp_idx;
  logic m_done = 1'b0, s_done = 1'b0;
  logic [N-1:0] m_ret = '0, s_ret = '0;
  logic model_en = 1'b0;

  assign fib_done = m_done | s_done;
  assign fib_ret  = m_done ? m_ret : s_ret;

  fib_sweep_ctrl #(.N(N), .HOLD(HOLD), .TMO(TMO)) dut (
    .clk(clk), .reset(reset), .run(run), .single(single),
    .fib_start(fib_start), .fib_steps(fib_steps),
    .fib_done(fib_done), .fib_ret(fib_ret),
    .disp_val(disp_val), .disp_idx(disp_idx),
    .ovf(ovf), .err(err), .busy(busy)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  int cyc = 0;
  int nstarts = 0, start_len = 0, last_start = -1;
  logic chk_period = 1'b0;
  exp_t sb[$];
  exp_t sweep_tbl[13];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] fibm(input logic [N-1:0] k);
    logic [N-1:0] a = '0, b = N'(1), t;
    for (int i = 0; i < int'(k); i++) begin
      t = a + b; a = b; b = t;
    end
    return a;
  endfunction

  always @(posedge clk) cyc++;

  // Start-pulse monitor: width, count and sweep period.
  initial forever begin
    @(negedge clk);
    if (fib_start) begin
      if (start_len == 0) begin
        nstarts++;
        if (chk_period && last_start >= 0) chk("start_period", cyc - last_start, 1 + L + HOLD);
        last_start = cyc;
      end
      start_len++;
    end else if (start_len > 0) begin
      chk("start_width", start_len, 1);
      start_len = 0;
    end
  end

  // Datapath model; checks the scoreboard on the cycle after each latch.
  initial forever begin
    logic [N-1:0] st;
    exp_t e;
    @(negedge clk);
    if (fib_start && model_en) begin
      st = fib_steps;
      repeat (L) @(posedge clk);
      #1 m_done = 1'b1; m_ret = fibm(st);
      @(posedge clk);
      #1 m_done = 1'b0;
      @(negedge clk);
      if (sb.size() == 0) begin
        chk("sb_unexpected", 1, 0);
      end else begin
        e = sb.pop_front();
        chk("disp_idx", int'(disp_idx), int'(e.idx));
        chk("disp_val", int'(disp_val), int'(e.val));
        chk("ovf", int'(ovf), int'(e.ovf));
      end
    end
  end

  task automatic wait_idle();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    chk("idle_reached", int'(busy), 0);
  endtask

  task automatic wait_start();
    for (int i = 0; i < 60; i++) begin
      if (fib_start) break;
      @(negedge clk);
    end
    chk("start_seen", int'(fib_start), 1);
  endtask

  task automatic pulse_single();
    single = 1'b1;
    @(negedge clk);
    single = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_disp_val"}, int'(disp_val), 0);
    chk({tag, "_disp_idx"}, int'(disp_idx), 0);
    chk({tag, "_steps"}, int'(fib_steps), 0);
    chk({tag, "_start"}, int'(fib_start), 0);
    chk({tag, "_ovf"}, int'(ovf), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int n;
    // Sweep from index 0: fib mod 64, index 11 gives 25 < 55 -> overflow, restart at 0.
    sweep_tbl[0]  = '{6'd0,  6'd0,  1'b0};
    sweep_tbl[1]  = '{6'd1,  6'd1,  1'b0};
    sweep_tbl[2]  = '{6'd2,  6'd1,  1'b0};
    sweep_tbl[3]  = '{6'd3,  6'd2,  1'b0};
    sweep_tbl[4]  = '{6'd4,  6'd3,  1'b0};
    sweep_tbl[5]  = '{6'd5,  6'd5,  1'b0};
    sweep_tbl[6]  = '{6'd6,  6'd8,  1'b0};
    sweep_tbl[7]  = '{6'd7,  6'd13, 1'b0};
    sweep_tbl[8]  = '{6'd8,  6'd21, 1'b0};
    sweep_tbl[9]  = '{6'd9,  6'd34, 1'b0};
    sweep_tbl[10] = '{6'd10, 6'd55, 1'b0};
    sweep_tbl[11] = '{6'd11, 6'd25, 1'b1};
    sweep_tbl[12] = '{6'd0,  6'd0,  1'b1};

    @(negedge clk);
    do_reset();
    repeat (10) @(negedge clk);
    chk_zero("rst");
    chk("idle_starts", nstarts, 0);

    // Three single steps.
    model_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(sweep_tbl[i]);
      pulse_single();
      wait_idle();
    end
    chk("single_starts", nstarts, 3);
    chk("single_drained", sb.size(), 0);

    // Run dropped during WAIT: result at index 3 still latched, then idle with idx 4.
    sb.push_back(sweep_tbl[3]);
    run = 1'b1;
    @(negedge clk);
    wait_start();
    @(negedge clk);
    run = 1'b0;
    wait_idle();
    chk("drop_idx_adv", int'(fib_steps), 4);
    chk("drop_drained", sb.size(), 0);
    sb.push_back(sweep_tbl[4]);
    pulse_single();
    wait_idle();

    // Timeout: no done; WAIT lasts TMO cycles, err visible on the next one.
    model_en = 1'b0;
    pulse_single();
    wait_start();
    n = 0;
    for (int i = 0; i < 3 * TMO; i++) begin
      @(negedge clk);
      n++;
      if (err) break;
    end
    chk("tmo_cycles", n, TMO + 1);
    chk("tmo_err", int'(err), 1);
    chk("tmo_busy", int'(busy), 0);
    chk("tmo_disp_val", int'(disp_val), 3);
    chk("tmo_disp_idx", int'(disp_idx), 4);
    chk("tmo_idx", int'(fib_steps), 5);
    pulse_single();
    wait_start();
    wait_idle();
    chk("tmo_err_sticky", int'(err), 1);

    // Continuous sweep through overflow.
    do_reset();
    @(negedge clk);
    chk("rst2_err", int'(err), 0);
    chk("rst2_idx", int'(fib_steps), 0);
    model_en = 1'b1;
    for (int i = 0; i < 13; i++) sb.push_back(sweep_tbl[i]);
    last_start = -1;
    chk_period = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (sb.size() == 0) break;
    end
    run = 1'b0;
    chk("sweep_drained", sb.size(), 0);
    wait_idle();
    chk_period = 1'b0;
    chk("sweep_idx_after", int'(fib_steps), 1);
    chk("sweep_ovf_sticky", int'(ovf), 1);

    // Reset in WAIT, then a stale done must be ignored.
    model_en = 1'b0;
    pulse_single();
    wait_start();
    @(negedge clk);
    do_reset();
    s_done = 1'b1; s_ret = 6'd5;
    @(negedge clk);
    s_done = 1'b0;
    repeat (2) @(negedge clk);
    chk_zero("stale");

    chk("sb_left", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end
endmodule
